// File: rtl/dram_pkg.sv
// dram_pkg: shared definitions for the DRAM controller slice.
// Holds the FSM state codes, the byte-address field layout,
// the latched-operation record and the odd-parity helpers.
package dram_pkg;

  // Byte address layout: [17:16] bank, [15:8] row, [7:0] column
  localparam int ADDR_W  = 18;
  localparam int BANK_HI = 17;
  localparam int BANK_LO = 16;
  localparam int ROW_HI  = 15;
  localparam int ROW_LO  = 8;
  localparam int COL_HI  = 7;
  localparam int COL_LO  = 0;

  // Controller states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_COL  = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_PRE  = 3'd4;

  // Operation captured at accept time (bus access or refresh)
  typedef struct packed {
    logic       rfsh;
    logic       wr;
    logic [1:0] bank;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] wdata;
  } op_t;

  // Parity bit that makes the 9 stored bits hold an odd number of ones
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // True when data plus parity bit hold an odd number of ones
  function automatic logic par_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/dram_if.sv
// dram_if: bundles the CPU/DMA request bus and the bank-side DRAM pins.
// The slave modport is the controller; the master modport is the
// surrounding system (requester plus ram_bank array).
interface dram_if #(
  parameter int NBANKS = 4
);

  // Requester side
  logic              req;
  logic              wr;
  logic [17:0]       addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ack;
  logic              busy;
  logic              par_err;
  logic              par_clr;

  // Bank side
  logic [7:0]        ma;
  logic [7:0]        md_o;
  logic              mdp_o;
  logic [7:0]        md_i;
  logic              mdp_i;
  logic              md_oe;
  logic [NBANKS-1:0] ras_n;
  logic              cas_n;
  logic              we_n;

  modport slave (
    input  req, wr, addr, wdata, par_clr, md_i, mdp_i,
    output rdata, ack, busy, par_err, ma, md_o, mdp_o, md_oe, ras_n, cas_n, we_n
  );

  modport master (
    output req, wr, addr, wdata, par_clr, md_i, mdp_i,
    input  rdata, ack, busy, par_err, ma, md_o, mdp_o, md_oe, ras_n, cas_n, we_n
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: periodic refresh request generator.
// Raises a sticky pending flag every REFRESH_PERIOD cycles and keeps the
// row/bank pointers for the next refresh. Only built with DRAM_REFRESH_EN.
module dram_refresh_timer #(
  parameter int NBANKS         = 4,
  parameter int REFRESH_PERIOD = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
  output logic       pend,
  output logic [7:0] row,
  output logic [1:0] bank
);

  localparam int PW = $clog2(REFRESH_PERIOD + 1);

  logic [PW-1:0] period_cnt;
  logic          fire;

  assign fire = (period_cnt == PW'(REFRESH_PERIOD - 1));

  // Period counter; a new tick re-arms pending even while a refresh is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      pend       <= 1'b0;
    end else begin
      period_cnt <= fire ? '0 : period_cnt + 1'b1;
      if (fire)      pend <= 1'b1;
      else if (take) pend <= 1'b0;
    end
  end

  // Bank pointer steps per refresh; row steps each time the bank pointer wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
      row  <= '0;
    end else if (take) begin
      if (bank == 2'(NBANKS - 1)) begin
        bank <= '0;
        row  <= row + 8'd1;
      end else begin
        bank <= bank + 2'd1;
      end
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: byte-wide DRAM controller driving multiplexed RAS/CAS cycles
// into up to four 64 KB banks, with odd parity generate/check and a sticky
// parity error. Optional on-chip refresh scheduling: define DRAM_REFRESH_EN.
// All outputs are registered from the next-state decode so they line up
// with the state they belong to.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int NBANKS         = 4,
  parameter int CAS_WAIT       = 2,
  parameter int T_PRE          = 1,
  parameter int REFRESH_PERIOD = 234
) (
  input  logic   clk,
  input  logic   rst,
  dram_if.slave  bus
);

  logic [2:0]        state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  op_t               op, op_nx;

  logic              rfsh_pend;
  logic [7:0]        rfsh_row;
  logic [1:0]        rfsh_bank;

  logic [NBANKS-1:0] ras_n_q, ras_n_nx;
  logic              cas_n_q, cas_n_nx;
  logic              we_n_q, we_n_nx;
  logic [7:0]        ma_q, ma_nx;
  logic [7:0]        md_o_q, md_o_nx;
  logic              mdp_o_q, mdp_o_nx;
  logic              md_oe_q, md_oe_nx;
  logic              ack_q, ack_nx;
  logic              busy_q;
  logic [7:0]        rdata_q;
  logic              par_err_q;

  logic              bank_ok;
  logic              rd_capture;
  logic              par_set;

`ifdef DRAM_REFRESH_EN
  dram_refresh_timer #(
    .NBANKS         (NBANKS),
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .take (state == ST_IDLE && rfsh_pend),
    .pend (rfsh_pend),
    .row  (rfsh_row),
    .bank (rfsh_bank)
  );
`else
  assign rfsh_pend = 1'b0;
  assign rfsh_row  = '0;
  assign rfsh_bank = '0;
`endif

  // Read data is sampled on the last HOLD cycle of a bus read only
  assign bank_ok    = (int'(op.bank) < NBANKS);
  assign rd_capture = (state == ST_HOLD) && (cnt == 8'(CAS_WAIT - 1)) && !op.wr && !op.rfsh;
  assign par_set    = rd_capture && bank_ok && !par_ok(bus.md_i, bus.mdp_i);

  // Next-state, cycle counter and operation latch; refresh wins over req in IDLE
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (rfsh_pend) begin
          state_nx    = ST_ROW;
          op_nx.rfsh  = 1'b1;
          op_nx.wr    = 1'b0;
          op_nx.bank  = rfsh_bank;
          op_nx.row   = rfsh_row;
          op_nx.col   = '0;
          op_nx.wdata = '0;
        end else if (bus.req) begin
          state_nx    = ST_ROW;
          op_nx.rfsh  = 1'b0;
          op_nx.wr    = bus.wr;
          op_nx.bank  = bus.addr[BANK_HI:BANK_LO];
          op_nx.row   = bus.addr[ROW_HI:ROW_LO];
          op_nx.col   = bus.addr[COL_HI:COL_LO];
          op_nx.wdata = bus.wdata;
        end
      end
      ST_ROW: state_nx = ST_COL;
      ST_COL: begin
        state_nx = ST_HOLD;
        cnt_nx   = '0;
      end
      ST_HOLD: begin
        if (cnt == 8'(CAS_WAIT - 1)) begin
          state_nx = ST_PRE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_PRE: begin
        if (cnt == 8'(T_PRE - 1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pin values for the state being entered; out-of-range banks get no ras_n
  always_comb begin
    ras_n_nx = '1;
    cas_n_nx = 1'b1;
    we_n_nx  = 1'b1;
    ma_nx    = '0;
    md_o_nx  = '0;
    mdp_o_nx = 1'b0;
    md_oe_nx = 1'b0;
    ack_nx   = 1'b0;
    case (state_nx)
      ST_ROW: begin
        ma_nx = op_nx.row;
        for (int b = 0; b < NBANKS; b++)
          if (op_nx.bank == 2'(b)) ras_n_nx[b] = 1'b0;
      end
      ST_COL, ST_HOLD: begin
        ma_nx    = op_nx.col;
        cas_n_nx = 1'b0;
        for (int b = 0; b < NBANKS; b++)
          if (op_nx.bank == 2'(b)) ras_n_nx[b] = 1'b0;
        if (op_nx.wr) begin
          we_n_nx  = 1'b0;
          md_oe_nx = 1'b1;
          md_o_nx  = op_nx.wdata;
          mdp_o_nx = odd_par(op_nx.wdata);
        end
      end
      ST_PRE: ack_nx = (state == ST_HOLD) && !op.rfsh;
      default: ;
    endcase
  end

  // State and output registers; reset aborts any access mid-cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op        <= '0;
      ras_n_q   <= '1;
      cas_n_q   <= 1'b1;
      we_n_q    <= 1'b1;
      ma_q      <= '0;
      md_o_q    <= '0;
      mdp_o_q   <= 1'b0;
      md_oe_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state     <= state_nx;
      cnt       <= cnt_nx;
      op        <= op_nx;
      ras_n_q   <= ras_n_nx;
      cas_n_q   <= cas_n_nx;
      we_n_q    <= we_n_nx;
      ma_q      <= ma_nx;
      md_o_q    <= md_o_nx;
      mdp_o_q   <= mdp_o_nx;
      md_oe_q   <= md_oe_nx;
      ack_q     <= ack_nx;
      busy_q    <= (state_nx != ST_IDLE);
      if (rd_capture) rdata_q <= bank_ok ? bus.md_i : 8'hFF;
      par_err_q <= par_set | (par_err_q & ~bus.par_clr);
    end
  end

  assign bus.ras_n   = ras_n_q;
  assign bus.cas_n   = cas_n_q;
  assign bus.we_n    = we_n_q;
  assign bus.ma      = ma_q;
  assign bus.md_o    = md_o_q;
  assign bus.mdp_o   = mdp_o_q;
  assign bus.md_oe   = md_oe_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.rdata   = rdata_q;
  assign bus.par_err = par_err_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed table-driven bench for dram_ctrl with a simple
// behavioural bank array; a second instance with NBANKS=2 covers the
// out-of-range bank path. The refresh scenario is built with DRAM_REFRESH_EN.
module tb_dram_ctrl;

  localparam int RP = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_if #(.NBANKS(4)) bus ();
  dram_if #(.NBANKS(2)) bus2 ();

  dram_ctrl #(.NBANKS(4), .CAS_WAIT(2), .T_PRE(1), .REFRESH_PERIOD(RP)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  dram_ctrl #(.NBANKS(2), .CAS_WAIT(2), .T_PRE(1), .REFRESH_PERIOD(RP)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  // Bank array model: row latched on RAS-only edge, read/write at each CAS edge
  logic [8:0] mem [0:262143];
  logic [7:0] row_q [0:3];
  logic [8:0] rd_q = 9'h0;
  logic       corrupt = 1'b0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.ras_n[b] === 1'b0 && bus.cas_n === 1'b1) row_q[b] <= bus.ma;
      if (bus.ras_n[b] === 1'b0 && bus.cas_n === 1'b0) begin
        if (bus.we_n === 1'b0) mem[{b[1:0], row_q[b], bus.ma}] <= {bus.mdp_o, bus.md_o};
        else                   rd_q <= mem[{b[1:0], row_q[b], bus.ma}];
      end
    end
  end

  assign bus.md_i  = rd_q[7:0];
  assign bus.mdp_i = rd_q[8] ^ corrupt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One access on the main instance; called at a negedge with the DUT idle
  task automatic access(input logic w, input logic [17:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic perr,
                        output logic [3:0] ras_seen, output logic mdp_seen,
                        output logic [7:0] cas_pat);
    lat = -1; rd = '0; perr = 1'b0; ras_seen = '0; mdp_seen = 1'b0; cas_pat = '0;
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ras_seen = ras_seen | ~bus.ras_n;
      cas_pat  = {cas_pat[6:0], ~bus.cas_n};
      if (bus.md_oe) mdp_seen = bus.mdp_o;
      if (bus.ack) begin
        lat = k; rd = bus.rdata; perr = bus.par_err;
        break;
      end
    end
    bus.req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [7:0]  wdata;
    logic        bad_par;
    logic [3:0]  exp_ras;
    logic [7:0]  exp_rd;
    logic        exp_mdp;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [11];

  int         lat;
  logic [7:0] rd;
  logic       perr;
  logic [3:0] ras_seen;
  logic       mdp_seen;
  logic [7:0] cas_pat;

  initial begin
    //          wr    addr        wdata  bad   ras    rdata  mdp   perr
    vecs[0]  = '{1'b1, 18'h0_1234, 8'hA5, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 18'h0_1234, 8'h00, 1'b0, 4'h1, 8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 18'h0_0010, 8'h3D, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 18'h1_0010, 8'hC3, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 18'h3_0010, 8'h7F, 1'b0, 4'h8, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 18'h1_0010, 8'h00, 1'b0, 4'h2, 8'hC3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 18'h3_0010, 8'h00, 1'b0, 4'h8, 8'h7F, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 18'h0_0010, 8'h00, 1'b0, 4'h1, 8'h3D, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 18'h2_FFFF, 8'h00, 1'b0, 4'h4, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 18'h2_FFFF, 8'h00, 1'b0, 4'h4, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 18'h0_1234, 8'h00, 1'b1, 4'h1, 8'hA5, 1'b0, 1'b1};

    bus.req = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0; bus.par_clr = 0;
    bus2.req = 0; bus2.wr = 0; bus2.addr = '0; bus2.wdata = '0; bus2.par_clr = 0;
    bus2.md_i = 8'h00; bus2.mdp_i = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst ras_n",   bus.ras_n,   32'hF);
    check("rst cas_n",   bus.cas_n,   1);
    check("rst we_n",    bus.we_n,    1);
    check("rst ma",      bus.ma,      0);
    check("rst md_o",    bus.md_o,    0);
    check("rst mdp_o",   bus.mdp_o,   0);
    check("rst md_oe",   bus.md_oe,   0);
    check("rst ack",     bus.ack,     0);
    check("rst rdata",   bus.rdata,   0);
    check("rst par_err", bus.par_err, 0);
    check("rst busy",    bus.busy,    0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single accesses
    for (int i = 0; i < 11; i++) begin
      corrupt = vecs[i].bad_par;
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, perr, ras_seen, mdp_seen, cas_pat);
      corrupt = 1'b0;
      check($sformatf("v%0d ack latency", i), lat, 5);
      check($sformatf("v%0d ras_n lanes", i), ras_seen, vecs[i].exp_ras);
      check($sformatf("v%0d par_err", i), perr, vecs[i].exp_perr);
      if (vecs[i].wr) check($sformatf("v%0d mdp_o", i), mdp_seen, vecs[i].exp_mdp);
      else            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      if (i == 0)     check("v0 cas_n pattern ROW/COL/HOLD/HOLD/PRE", cas_pat, 8'h0E);
    end

    // Sticky par_err, clear, and set-beats-clear
    repeat (3) @(negedge clk);
    check("par_err sticky", bus.par_err, 1);
    bus.par_clr = 1'b1;
    @(negedge clk);
    bus.par_clr = 1'b0;
    check("par_err cleared", bus.par_err, 0);
    corrupt = 1'b1;
    bus.par_clr = 1'b1;
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 18'h0_0010;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.ack) begin lat = k; perr = bus.par_err; break; end
    end
    bus.req = 1'b0; bus.par_clr = 1'b0; corrupt = 1'b0;
    check("set vs clr latency", lat, 5);
    check("set wins over par_clr", perr, 1);
    repeat (2) @(negedge clk);
    check("par_err held after clr drop", bus.par_err, 1);

    // Continuous req: three reads, acks 6 cycles apart, RAS high between
    begin
      int acks [3];
      int na = 0;
      logic prev_ack = 1'b0;
      acks = '{-1, -1, -1};
      bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 18'h0_1234;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (prev_ack) check($sformatf("b2b ras_n idle after ack %0d", na), bus.ras_n, 32'hF);
        prev_ack = bus.ack;
        if (bus.ack) begin
          acks[na] = k;
          na++;
          if (na == 3) begin
            check("b2b third rdata", bus.rdata, 8'hA5);
            break;
          end
        end
      end
      bus.req = 1'b0;
      check("b2b first ack", acks[0], 5);
      check("b2b ack spacing 1-2", acks[1] - acks[0], 6);
      check("b2b ack spacing 2-3", acks[2] - acks[1], 6);
      @(negedge clk);
      @(negedge clk);
    end

    // Out-of-range bank on a 2-bank instance; bank 1 read with bad parity as contrast
    begin
      logic [1:0] ras2;
      for (int t = 0; t < 2; t++) begin
        ras2 = '0; lat = -1; rd = '0; perr = 1'b0;
        bus2.req = 1'b1; bus2.wr = 1'b0; bus2.addr = (t == 0) ? 18'h3_0010 : 18'h1_0010;
        for (int k = 1; k <= 20; k++) begin
          @(negedge clk);
          ras2 = ras2 | ~bus2.ras_n;
          if (bus2.ack) begin lat = k; rd = bus2.rdata; perr = bus2.par_err; break; end
        end
        bus2.req = 1'b0;
        @(negedge clk);
        if (t == 0) begin
          check("nb2 bank3 latency", lat, 5);
          check("nb2 bank3 rdata",   rd, 8'hFF);
          check("nb2 bank3 ras_n",   ras2, 0);
          check("nb2 bank3 par_err", perr, 0);
        end else begin
          check("nb2 bank1 ras_n",   ras2, 2'b10);
          check("nb2 bank1 rdata",   rd, 8'h00);
          check("nb2 bank1 par_err", perr, 1);
        end
      end
    end

    // Reset in HOLD of a write
    begin
      logic ack_seen = 1'b0;
      bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 18'h0_0020; bus.wdata = 8'h55;
      repeat (3) @(negedge clk);
      check("pre-reset write in HOLD md_oe", bus.md_oe, 1);
      rst = 1'b1; bus.req = 1'b0;
      @(negedge clk);
      check("abort ras_n",   bus.ras_n,   32'hF);
      check("abort cas_n",   bus.cas_n,   1);
      check("abort we_n",    bus.we_n,    1);
      check("abort md_oe",   bus.md_oe,   0);
      check("abort busy",    bus.busy,    0);
      check("abort ack",     bus.ack,     0);
      check("abort par_err", bus.par_err, 0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        ack_seen = ack_seen | bus.ack;
      end
      check("no ack after abort", ack_seen, 0);
    end

`ifdef DRAM_REFRESH_EN
    // Refresh pending in the same cycle req rises: refresh first, then the read
    begin
      logic oe_seen = 1'b0;
      logic ack_early = 1'b0;
      logic [3:0] rras = 4'h0;
      logic [7:0] rma = 8'hFF;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (RP) @(negedge clk);
      bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 18'h0_1234;
      lat = -1; rd = '0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (k == 1) begin rras = bus.ras_n; rma = bus.ma; end
        if (k <= 5) begin
          oe_seen   = oe_seen | bus.md_oe;
          ack_early = ack_early | bus.ack;
        end
        if (bus.ack) begin lat = k; rd = bus.rdata; break; end
      end
      bus.req = 1'b0;
      check("rfsh ROW ras_n bank0", rras, 4'hE);
      check("rfsh ROW ma row0",     rma, 8'h00);
      check("rfsh md_oe low",       oe_seen, 0);
      check("rfsh no ack",          ack_early, 0);
      check("rfsh then req ack",    lat, 11);
      check("rfsh then req rdata",  rd, 8'hA5);
      check("rfsh bank counter",    dut.u_refresh.bank, 1);
      check("rfsh row counter",     dut.u_refresh.row, 0);
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
